board_scanner: RTL and testbench

Read-side companion to the per-player shot-marking register. On request it sequentially scans all N×N board cells through a registered read port, fetching the "fired" bit and the "ship present" bit for each cell. It classifies every cell into empty/miss/hit and stores the result in a 2-bit-per-cell snapshot for the VGA renderer. It also produces the hit count, the shot count and a game-over flag for the game FSM.

---
 rtl/board_pkg.sv | 39 +++
 rtl/board_scanner_if.sv | 23 ++
 rtl/board_scan_ctr.sv | 44 ++++
 rtl/board_scanner.sv | 142 ++++++++++++++
 tb/tb_board_scanner.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/board_pkg.sv
// Shared board definitions for the shot-marking register, the scanner and the VGA renderer.
// Holds board geometry, cell classification and scanner FSM encoding.
package board_pkg;

    localparam int N      = 5;
    localparam int IDX_W  = $clog2(N);
    localparam int CNT_W  = $clog2(N * N + 1);
    localparam int CELLS  = N * N;
    localparam int ADDR_W = $clog2(N * N);

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'd0,
        CELL_MISS  = 2'd1,
        CELL_HIT   = 2'd2
    } cell_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } scan_state_t;

    // An unfired cell shows as empty even when a ship sits there.
    function automatic cell_t classify(input logic shot, input logic ship);
        if (!shot)
            return CELL_EMPTY;
        else if (ship)
            return CELL_HIT;
        else
            return CELL_MISS;
    endfunction

    function automatic logic [ADDR_W-1:0] cell_idx(input logic [IDX_W-1:0] fila,
                                                   input logic [IDX_W-1:0] columna);
        return ADDR_W'(int'(fila) * N + int'(columna));
    endfunction

endpackage

// File: rtl/board_scanner_if.sv
// Registered read port between the board scanner and the shot/ship storage.
interface board_scanner_if import board_pkg::*; ();

    logic [IDX_W-1:0] rd_fila;
    logic [IDX_W-1:0] rd_columna;
    logic             rd_shot;
    logic             rd_ship;

    modport master (
        output rd_fila,
        output rd_columna,
        input  rd_shot,
        input  rd_ship
    );

    modport slave (
        input  rd_fila,
        input  rd_columna,
        output rd_shot,
        output rd_ship
    );

endinterface

// File: rtl/board_scan_ctr.sv
// Row-major cell address counter plus a one-cycle delayed copy that indexes the
// snapshot write, matching the storage's single-cycle read latency.
module board_scan_ctr
    import board_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [IDX_W-1:0] fila,
    output logic [IDX_W-1:0] columna,
    output logic             last,
    output logic [IDX_W-1:0] cap_fila,
    output logic [IDX_W-1:0] cap_columna
);

    assign last = (fila == IDX_W'(N - 1)) && (columna == IDX_W'(N - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; cap_* must see the address from before this edge's update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fila        <= '0;
            columna     <= '0;
            cap_fila    <= '0;
            cap_columna <= '0;
        end else begin
            if (clr) begin
                fila    <= '0;
                columna <= '0;
            end else if (en) begin
                if (columna == IDX_W'(N - 1)) begin
                    columna <= '0;
                    fila    <= last ? '0 : fila + 1'b1;
                end else begin
                    columna <= columna + 1'b1;
                end
            end
            cap_fila    <= fila;
            cap_columna <= columna;
        end
    end

endmodule

// File: rtl/board_scanner.sv
// Scans every board cell through the registered read port, keeps a 2-bit-per-cell
// snapshot for the renderer and publishes hit/shot counts and game-over atomically.
module board_scanner
    import board_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    board_scanner_if.master   rd,
    output logic              busy,
    output logic              done,
    input  logic [IDX_W-1:0]  q_fila,
    input  logic [IDX_W-1:0]  q_columna,
    output logic [1:0]        q_estado,
    output logic [CNT_W-1:0]  hits,
    output logic [CNT_W-1:0]  shots,
    output logic              all_sunk
);

    scan_state_t      state, state_nx;
    logic             ctr_clr, ctr_en, ctr_last;
    logic [IDX_W-1:0] cap_fila, cap_columna;
    logic             data_vld;

    logic [CNT_W-1:0] sh_shots, sh_hits, sh_ships;
    logic [CNT_W-1:0] shots_nx, hits_nx, ships_nx;
    logic             sunk_nx;

    cell_t            snap [CELLS];

    board_scan_ctr u_ctr (
        .clk         (clk),
        .rst         (rst),
        .clr         (ctr_clr),
        .en          (ctr_en),
        .fila        (rd.rd_fila),
        .columna     (rd.rd_columna),
        .last        (ctr_last),
        .cap_fila    (cap_fila),
        .cap_columna (cap_columna)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        ctr_clr  = 1'b0;
        ctr_en   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            S_IDLE: begin
                ctr_clr = 1'b1;
                if (start)
                    state_nx = S_SCAN;
            end
            S_SCAN: begin
                busy   = 1'b1;
                ctr_en = 1'b1;
                if (ctr_last)
                    state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                busy     = 1'b1;
                state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Read data lags the presented address by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            data_vld <= 1'b0;
        else
            data_vld <= (state == S_SCAN);
    end

    // The last cell is captured on the same edge the results publish, so the
    // published values are taken from the next-state accumulators.
    always_comb begin
        shots_nx = sh_shots + CNT_W'(data_vld && rd.rd_shot);
        hits_nx  = sh_hits  + CNT_W'(data_vld && rd.rd_shot && rd.rd_ship);
        ships_nx = sh_ships + CNT_W'(data_vld && rd.rd_ship);
        sunk_nx  = (ships_nx != '0) && (hits_nx == ships_nx);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_shots <= '0;
            sh_hits  <= '0;
            sh_ships <= '0;
            shots    <= '0;
            hits     <= '0;
            all_sunk <= 1'b0;
        end else begin
            if (state == S_IDLE) begin
                sh_shots <= '0;
                sh_hits  <= '0;
                sh_ships <= '0;
            end else begin
                sh_shots <= shots_nx;
                sh_hits  <= hits_nx;
                sh_ships <= ships_nx;
            end
            if (state == S_DRAIN) begin
                shots    <= shots_nx;
                hits     <= hits_nx;
                all_sunk <= sunk_nx;
            end
        end
    end

    // NOTE: the snapshot is built from flops, not RAM, because it must clear
    // instantly on reset and be read combinationally by the renderer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CELLS; i++)
                snap[i] <= CELL_EMPTY;
        end else if (data_vld) begin
            snap[cell_idx(cap_fila, cap_columna)] <= classify(rd.rd_shot, rd.rd_ship);
        end
    end

    always_comb begin
        q_estado = 2'd0;
        if ((q_fila < IDX_W'(N)) && (q_columna < IDX_W'(N)))
            q_estado = snap[cell_idx(q_fila, q_columna)];
    end

endmodule

// File: tb/tb_board_scanner.sv
// Randomised self-checking bench for board_scanner against a counting reference model.
module tb_board_scanner;
    import board_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [IDX_W-1:0] q_fila = '0;
    logic [IDX_W-1:0] q_columna = '0;
    logic [1:0]       q_estado;
    logic             busy, done, all_sunk;
    logic [CNT_W-1:0] hits, shots;

    int n_pass  = 0;
    int n_total = 0;

    bit shot_mem [N][N];
    bit ship_mem [N][N];

    board_scanner_if rdif ();

    board_scanner dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rd        (rdif),
        .busy      (busy),
        .done      (done),
        .q_fila    (q_fila),
        .q_columna (q_columna),
        .q_estado  (q_estado),
        .hits      (hits),
        .shots     (shots),
        .all_sunk  (all_sunk)
    );

    always #5 clk = ~clk;

    // Storage model: registered read, one-cycle latency.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rdif.rd_shot <= 1'b0;
            rdif.rd_ship <= 1'b0;
        end else begin
            rdif.rd_shot <= shot_mem[rdif.rd_fila][rdif.rd_columna];
            rdif.rd_ship <= ship_mem[rdif.rd_fila][rdif.rd_columna];
        end
    end

    // ---------------- reference model ----------------
    function automatic int m_shots();
        int s = 0;
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) s += int'(shot_mem[r][c]);
        return s;
    endfunction

    function automatic int m_hits();
        int s = 0;
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) s += int'(shot_mem[r][c] & ship_mem[r][c]);
        return s;
    endfunction

    function automatic int m_ships();
        int s = 0;
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) s += int'(ship_mem[r][c]);
        return s;
    endfunction

    function automatic bit m_sunk();
        return (m_ships() != 0) && (m_hits() == m_ships());
    endfunction

    function automatic logic [1:0] m_cell(input int r, input int c);
        if (!shot_mem[r][c]) return 2'd0;
        return ship_mem[r][c] ? 2'd2 : 2'd1;
    endfunction

    task automatic clear_board();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                shot_mem[r][c] = 1'b0;
                ship_mem[r][c] = 1'b0;
            end
    endtask

    task automatic random_board(input int pct_shot, input int pct_ship);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                shot_mem[r][c] = ($urandom_range(99) < pct_shot);
                ship_mem[r][c] = ($urandom_range(99) < pct_ship);
            end
    endtask

    task automatic query(input int r, input int c);
        q_fila    = IDX_W'(r);
        q_columna = IDX_W'(c);
        #1;
    endtask

    // Cells whose snapshot differs from expected (exp_zero forces an all-empty board).
    task automatic snap_errors(input bit exp_zero, output int errs);
        errs = 0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                query(r, c);
                if (q_estado !== (exp_zero ? 2'd0 : m_cell(r, c))) errs++;
            end
    endtask

    // One scan: start before E0, observe cycles 0..29 (cycle k = after edge Ek).
    // Returns early with rst asserted when rst_at is reached.
    int sc_ndone, sc_done_cyc, sc_addr_err, sc_overlap, sc_hits, sc_shots;
    bit sc_sunk;

    task automatic scan(input int pulse_at, input int rst_at);
        sc_ndone = 0; sc_done_cyc = -1; sc_addr_err = 0; sc_overlap = 0;
        sc_hits = -1; sc_shots = -1; sc_sunk = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (c < CELLS && (rdif.rd_fila !== IDX_W'(c / N) ||
                              rdif.rd_columna !== IDX_W'(c % N) || busy !== 1'b1))
                sc_addr_err++;
            if (done === 1'b1) begin
                sc_ndone++;
                sc_done_cyc = c;
                sc_hits  = int'(hits);
                sc_shots = int'(shots);
                sc_sunk  = all_sunk;
            end
            if (busy === 1'b1 && done === 1'b1) sc_overlap++;
            start = (c == pulse_at);
            if (c == rst_at) begin
                #2 rst = 1'b1;
                return;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int errs;
        #1;
        n_total++;
        if ({busy, done, hits, shots, all_sunk} !== '0)
            $display("FAIL reset_powerup_outputs: got %b want 0", {busy, done, hits, shots, all_sunk});
        else n_pass++;
        #20 rst = 1'b0;
        random_board(80, 60);
        scan(-1, -1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_total++;
        if ({busy, done, hits, shots, all_sunk, rdif.rd_fila, rdif.rd_columna} !== '0)
            $display("FAIL reset_async_outputs: got %b want 0",
                     {busy, done, hits, shots, all_sunk, rdif.rd_fila, rdif.rd_columna});
        else n_pass++;
        snap_errors(1'b1, errs);
        n_total++;
        if (errs !== 0) $display("FAIL reset_snapshot: %0d nonzero cells, want 0", errs);
        else n_pass++;
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic test_empty();
        clear_board();
        scan(-1, -1);
        n_total++;
        if (sc_addr_err !== 0) $display("FAIL empty_addr_order: %0d bad cycles, want 0", sc_addr_err);
        else n_pass++;
        n_total++;
        if (sc_ndone !== 1 || sc_done_cyc !== 26)
            $display("FAIL empty_done: count %0d cycle %0d, want 1 at 26", sc_ndone, sc_done_cyc);
        else n_pass++;
        n_total++;
        if (sc_overlap !== 0) $display("FAIL empty_busy_done_overlap: %0d, want 0", sc_overlap);
        else n_pass++;
        n_total++;
        if (sc_hits !== 0 || sc_shots !== 0 || sc_sunk !== 1'b0)
            $display("FAIL empty_counts: hits %0d shots %0d sunk %0b, want 0 0 0", sc_hits, sc_shots, sc_sunk);
        else n_pass++;
    endtask

    task automatic test_mixed();
        clear_board();
        ship_mem[0][0] = 1; ship_mem[0][1] = 1;
        shot_mem[0][0] = 1; shot_mem[4][4] = 1;
        scan(-1, -1);
        n_total++;
        if (sc_hits !== 1 || sc_shots !== 2 || sc_sunk !== 1'b0)
            $display("FAIL mixed_counts: hits %0d shots %0d sunk %0b, want 1 2 0", sc_hits, sc_shots, sc_sunk);
        else n_pass++;
        query(0, 0);
        n_total++;
        if (q_estado !== 2'd2) $display("FAIL mixed_q00: got %0d want 2", q_estado); else n_pass++;
        query(4, 4);
        n_total++;
        if (q_estado !== 2'd1) $display("FAIL mixed_q44: got %0d want 1", q_estado); else n_pass++;
        query(0, 1);
        n_total++;
        if (q_estado !== 2'd0) $display("FAIL mixed_q01: got %0d want 0", q_estado); else n_pass++;
        query(5, 0);
        n_total++;
        if (q_estado !== 2'd0) $display("FAIL mixed_q50_range: got %0d want 0", q_estado); else n_pass++;
        query(0, 7);
        n_total++;
        if (q_estado !== 2'd0) $display("FAIL mixed_q07_range: got %0d want 0", q_estado); else n_pass++;
    endtask

    task automatic test_all_sunk();
        shot_mem[0][1] = 1; shot_mem[4][4] = 0;
        scan(-1, -1);
        n_total++;
        if (sc_hits !== 2 || sc_shots !== 2 || sc_sunk !== 1'b1)
            $display("FAIL sunk_counts: hits %0d shots %0d sunk %0b, want 2 2 1", sc_hits, sc_shots, sc_sunk);
        else n_pass++;
        clear_board();
        shot_mem[1][2] = 1; shot_mem[3][0] = 1; shot_mem[4][3] = 1;
        scan(-1, -1);
        n_total++;
        if (sc_hits !== 0 || sc_shots !== 3 || sc_sunk !== 1'b0)
            $display("FAIL sunk_noships: hits %0d shots %0d sunk %0b, want 0 3 0", sc_hits, sc_shots, sc_sunk);
        else n_pass++;
    endtask

    task automatic test_start_ignore();
        random_board(50, 40);
        scan(10, -1);
        n_total++;
        if (sc_ndone !== 1 || sc_done_cyc !== 26 || sc_addr_err !== 0)
            $display("FAIL start_ignored: done %0d at %0d addr_err %0d, want 1 at 26, 0",
                     sc_ndone, sc_done_cyc, sc_addr_err);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int d1 = -1, d2 = -1;
        bit gap_ok = 1'b0, reentry_ok = 1'b0;
        random_board(50, 40);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (d1 < 0) d1 = c; else d2 = c;
            end
            if (c == 27) gap_ok = (busy === 1'b0 && done === 1'b0);
            if (c == 28) begin
                reentry_ok = (busy === 1'b1 && rdif.rd_fila === '0 && rdif.rd_columna === '0);
                start = 1'b0;
            end
        end
        n_total++;
        if (!gap_ok || !reentry_ok)
            $display("FAIL b2b_reentry: idle@27 %0b addr00@28 %0b, want 1 1", gap_ok, reentry_ok);
        else n_pass++;
        n_total++;
        if (d1 !== 26 || d2 !== 54) $display("FAIL b2b_done: at %0d and %0d, want 26 and 54", d1, d2);
        else n_pass++;
        n_total++;
        if (hits !== CNT_W'(m_hits()) || shots !== CNT_W'(m_shots()))
            $display("FAIL b2b_counts: hits %0d shots %0d, want %0d %0d", hits, shots, m_hits(), m_shots());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int errs, nd = 0, nb = 0;
        random_board(90, 60);
        scan(-1, -1);
        scan(-1, 12);
        #1;
        n_total++;
        if (busy !== 1'b0 || hits !== '0 || shots !== '0 || all_sunk !== 1'b0)
            $display("FAIL midrst_outputs: busy %0b hits %0d shots %0d sunk %0b, want 0", busy, hits, shots, all_sunk);
        else n_pass++;
        snap_errors(1'b1, errs);
        n_total++;
        if (errs !== 0) $display("FAIL midrst_snapshot: %0d nonzero cells, want 0", errs);
        else n_pass++;
        @(negedge clk);
        #2 rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
            if (busy === 1'b1) nb++;
        end
        n_total++;
        if (nd !== 0 || nb !== 0) $display("FAIL midrst_no_done: done %0d busy %0d, want 0 0", nd, nb);
        else n_pass++;
        random_board(50, 50);
        scan(-1, -1);
        snap_errors(1'b0, errs);
        n_total++;
        if (sc_ndone !== 1 || sc_done_cyc !== 26 || sc_addr_err !== 0 || errs !== 0 ||
            sc_hits !== m_hits() || sc_shots !== m_shots() || sc_sunk !== m_sunk())
            $display("FAIL midrst_rescan: done %0d@%0d addr %0d snap %0d hits %0d/%0d shots %0d/%0d",
                     sc_ndone, sc_done_cyc, sc_addr_err, errs, sc_hits, m_hits(), sc_shots, m_shots());
        else n_pass++;
    endtask

    task automatic test_random();
        int errs;
        for (int t = 0; t < 8; t++) begin
            if (t == 0)      random_board(100, 30);
            else if (t == 1) begin random_board(0, 100); ship_mem[2][2] = 1; end
            else             random_board($urandom_range(100), $urandom_range(60));
            if (t == 2) for (int r = 0; r < N; r++) for (int c = 0; c < N; c++)
                if (ship_mem[r][c]) shot_mem[r][c] = 1;
            scan(-1, -1);
            n_total++;
            if (sc_ndone !== 1 || sc_done_cyc !== 26 || sc_addr_err !== 0)
                $display("FAIL rand%0d_timing: done %0d@%0d addr_err %0d", t, sc_ndone, sc_done_cyc, sc_addr_err);
            else n_pass++;
            n_total++;
            if (sc_hits !== m_hits() || sc_shots !== m_shots() || sc_sunk !== m_sunk())
                $display("FAIL rand%0d_counts: got %0d %0d %0b want %0d %0d %0b",
                         t, sc_hits, sc_shots, sc_sunk, m_hits(), m_shots(), m_sunk());
            else n_pass++;
            snap_errors(1'b0, errs);
            n_total++;
            if (errs !== 0) $display("FAIL rand%0d_snapshot: %0d cells wrong, want 0", t, errs);
            else n_pass++;
        end
    endtask

    initial begin
        clear_board();
        test_reset();
        test_empty();
        test_mixed();
        test_all_sunk();
        test_start_ignore();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
